// File: rtl/dsm_interp.sv
// dsm_interp: linear-interpolating upsampler in front of a 2nd-order
// delta-sigma DAC stage.
//
// Input samples arrive at the low rate over a valid/ready handshake and are
// buffered in a small FIFO. A divider produces the modulator tick strobe, and
// on every tick a value linearly interpolated between the previous and the
// current sample is registered onto dout. One sample spans 2**OSR_LOG2 ticks.
//
// Parameters
//   CKE_DIV    clocks per modulator tick (>= 2)
//   OSR_LOG2   log2 of ticks per input sample (1..8)
//   FIFO_DEPTH input FIFO entries (power of two, >= 2)
//
// Ports
//   clk       system clock
//   rst       asynchronous active-low reset
//   en        run enable for tick generation and interpolation
//   s_valid   input sample valid
//   s_ready   FIFO can accept a sample (not full)
//   s_data    signed 16-bit input sample
//   dout      signed interpolated value, to DAC din
//   cke       one-cycle modulator tick strobe, to DAC cke
//   underrun  one-cycle pulse: FIFO was empty at a sample boundary
//   level     current FIFO occupancy
module dsm_interp #(
    parameter int CKE_DIV    = 8,
    parameter int OSR_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [15:0]            s_data,
    output logic signed [15:0]            dout,
    output logic                          cke,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int CW = (CKE_DIV > 1) ? $clog2(CKE_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = 17 + OSR_LOG2;

    localparam logic [CW-1:0]       CNT_LAST   = CW'(CKE_DIV - 1);
    localparam logic [LW-1:0]       DEPTH_LVL  = LW'(FIFO_DEPTH);
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = {OSR_LOG2{1'b1}};

    // tick generator state
    logic [CW-1:0]       cnt_r;
    logic                cke_r;

    // interpolator state
    logic [OSR_LOG2-1:0] phase_r;
    logic signed [15:0]  prev_r;
    logic signed [15:0]  cur_r;
    logic signed [15:0]  dout_r;
    logic                underrun_r;

    // FIFO state
    logic [15:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wptr_r;
    logic [AW-1:0]       rptr_r;
    logic [LW-1:0]       level_r;
    logic                ready_r;

    // combinational helpers
    logic                boundary_s;
    logic                push_s;
    logic                pop_s;
    logic [LW-1:0]       level_nxt_s;
    logic signed [16:0]  diff_s;
    logic signed [PW-1:0] diff_x_s;
    logic signed [PW-1:0] phase_x_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] interp_s;
    logic                unused_s;

    assign boundary_s = cke_r && (phase_r == PHASE_LAST);
    assign push_s     = s_valid && ready_r;
    // Only entries resident before this edge can be popped: no bypass.
    assign pop_s      = boundary_s && (level_r != LW'(0));

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Interpolated value prev + floor((cur-prev)*phase / 2**OSR_LOG2).
    always_comb begin
        diff_s    = 17'sd0;
        diff_x_s  = '0;
        phase_x_s = '0;
        prod_s    = '0;
        interp_s  = '0;
        diff_s    = $signed({cur_r[15], cur_r}) - $signed({prev_r[15], prev_r});
        diff_x_s  = PW'(diff_s);
        phase_x_s = PW'({1'b0, phase_r});
        prod_s    = diff_x_s * phase_x_s;
        interp_s  = PW'(prev_r) + (prod_s >>> OSR_LOG2);
    end

    // The result always lies between prev and cur, so the bits above 15 are
    // pure sign copies and carry no information.
    assign unused_s = ^interp_s[PW-1:16];

    // Tick divider: cke is high for the cycle after cnt reaches its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CW'(0);
            cke_r <= 1'b0;
        end else if (en) begin
            cnt_r <= (cnt_r == CNT_LAST) ? CW'(0) : (cnt_r + CW'(1));
            cke_r <= (cnt_r == CNT_LAST);
        end else begin
            cnt_r <= CW'(0);
            cke_r <= 1'b0;
        end
    end

    // Per-tick interpolation, sample-boundary handover and underrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r    <= OSR_LOG2'(0);
            prev_r     <= 16'sd0;
            cur_r      <= 16'sd0;
            dout_r     <= 16'sd0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            if (cke_r) begin
                // dout uses the pre-boundary prev/cur on the boundary tick.
                dout_r <= interp_s[15:0];
                if (boundary_s) begin
                    prev_r <= cur_r;
                    if (pop_s) begin
                        cur_r <= mem_r[rptr_r];
                    end else begin
                        underrun_r <= 1'b1;
                    end
                end
            end
            if (!en) begin
                phase_r <= OSR_LOG2'(0);
            end else if (cke_r) begin
                phase_r <= phase_r + OSR_LOG2'(1);
            end
        end
    end

    // FIFO pointers, occupancy and registered ready (not full next cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r  <= AW'(0);
            rptr_r  <= AW'(0);
            level_r <= LW'(0);
            ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != DEPTH_LVL);
        end
    end

    // FIFO storage; contents are don't-care until written, pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= s_data;
        end
    end

    assign s_ready  = ready_r;
    assign dout     = dout_r;
    assign cke      = cke_r;
    assign underrun = underrun_r;
    assign level    = level_r;

endmodule

// File: tb/tb_dsm_interp.sv
// Self-checking bench for dsm_interp with CKE_DIV=4, OSR_LOG2=2, FIFO_DEPTH=4.
// Table-driven tick-by-tick dout/underrun expectations plus hand-written
// sequences for idle, backpressure, enable drop and asynchronous reset.
module tb_dsm_interp;

    localparam int CKE_DIV    = 4;
    localparam int OSR_LOG2   = 2;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               s_valid = 1'b0;
    logic signed [15:0] s_data = 16'sd0;
    logic               s_ready;
    logic signed [15:0] dout;
    logic               cke;
    logic               underrun;
    logic [2:0]         level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tick;
        int dout;
        int und;
    } vec_t;

    vec_t vecs [34];

    dsm_interp #(
        .CKE_DIV   (CKE_DIV),
        .OSR_LOG2  (OSR_LOG2),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .dout    (dout),
        .cke     (cke),
        .underrun(underrun),
        .level   (level)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input int t, input int d, input int u);
        vecs[i].tick = t;
        vecs[i].dout = d;
        vecs[i].und  = u;
    endtask

    // Reset for two edges, then release one time unit after an edge with en=e.
    task automatic do_reset(input logic e);
        en      = 1'b0;
        s_valid = 1'b0;
        rst     = 1'b0;
        step();
        step();
        en  = e;
        rst = 1'b1;
    endtask

    task automatic push(input int v);
        chk("push_ready", int'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 16'(v);
        step();
        s_valid = 1'b0;
    endtask

    // Wait for cke, then step over the tick edge so the new dout is visible.
    task automatic wait_tick();
        int n;
        n = 0;
        while (cke !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=%0d expected=<64", n);
        end
        step();
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wait_tick();
            chk($sformatf("dout_t%0d", vecs[i].tick), int'(dout), vecs[i].dout);
            chk($sformatf("underrun_t%0d", vecs[i].tick), int'(underrun), vecs[i].und);
        end
    endtask

    initial begin
        int acc;
        int n;
        int ok;

        // Ramp: 1000, 2000, 3000 queued before the first tick.
        setv(0, 0, 0, 0);      setv(1, 1, 0, 0);      setv(2, 2, 0, 0);
        setv(3, 3, 0, 0);      setv(4, 4, 0, 0);      setv(5, 5, 250, 0);
        setv(6, 6, 500, 0);    setv(7, 7, 750, 0);    setv(8, 8, 1000, 0);
        setv(9, 9, 1250, 0);   setv(10, 10, 1500, 0); setv(11, 11, 1750, 0);
        setv(12, 12, 2000, 0); setv(13, 13, 2250, 0); setv(14, 14, 2500, 0);
        setv(15, 15, 2750, 1); setv(16, 16, 3000, 0);
        // Negative floor and full-scale swing: -1, then -32768, 32767.
        setv(17, 0, 0, 0);       setv(18, 1, 0, 0);       setv(19, 2, 0, 0);
        setv(20, 3, 0, 0);       setv(21, 4, 0, 0);       setv(22, 5, -1, 0);
        setv(23, 6, -1, 0);      setv(24, 7, -1, 0);      setv(25, 8, -1, 0);
        setv(26, 9, -8193, 0);   setv(27, 10, -16385, 0); setv(28, 11, -24577, 0);
        setv(29, 12, -32768, 0); setv(30, 13, -16385, 0); setv(31, 14, -1, 0);
        setv(32, 15, 16383, 1);  setv(33, 16, 32767, 0);

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_dout", int'(dout), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_cke", int'(cke), 0);
        chk("rst_underrun", int'(underrun), 0);

        // Idle: cke every 4 edges, underrun every 16 cycles, dout stays 0.
        do_reset(1'b1);
        for (int i = 1; i <= 40; i++) begin
            step();
            chk($sformatf("idle_cke_e%0d", i), int'(cke), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("idle_und_e%0d", i), int'(underrun), (i == 17 || i == 33) ? 1 : 0);
            chk($sformatf("idle_dout_e%0d", i), int'(dout), 0);
        end

        // Ramp
        do_reset(1'b0);
        push(1000);
        push(2000);
        push(3000);
        chk("ramp_level", int'(level), 3);
        en = 1'b1;
        run_vecs(0, 16);

        // Negative floor and extremes
        do_reset(1'b0);
        push(-1);
        en = 1'b1;
        run_vecs(17, 20);
        push(-32768);
        push(32767);
        run_vecs(21, 33);

        // Backpressure with en=0
        do_reset(1'b0);
        s_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'(100 * (acc + 1));
            if (s_ready) acc++;
            step();
        end
        s_valid = 1'b0;
        chk("bp_accepted", acc, 4);
        chk("bp_level", int'(level), 4);
        chk("bp_ready", int'(s_ready), 0);
        en = 1'b1;
        wait_tick();
        wait_tick();
        wait_tick();
        chk("bp_ready_prepop", int'(s_ready), 0);
        wait_tick();
        chk("bp_level_pop", int'(level), 3);
        chk("bp_ready_pop", int'(s_ready), 1);
        chk("bp_dout_t3", int'(dout), 0);
        wait_tick();
        wait_tick();
        chk("bp_dout_t5", int'(dout), 25);

        // Asynchronous reset between edges while cke is high
        n = 0;
        while (cke !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("ar_cke_before", int'(cke), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_dout", int'(dout), 0);
        chk("ar_level", int'(level), 0);
        chk("ar_cke", int'(cke), 0);
        chk("ar_ready", int'(s_ready), 1);
        chk("ar_underrun", int'(underrun), 0);

        // Enable drop at phase 2
        do_reset(1'b0);
        push(1000);
        en = 1'b1;
        for (int i = 0; i < 6; i++) wait_tick();
        chk("ed_dout_t5", int'(dout), 250);
        en = 1'b0;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cke !== 1'b0 || dout !== 16'sd250) ok = 0;
        end
        chk("ed_hold", ok, 1);
        en = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (cke !== 1'b1 && n < 16);
        chk("ed_first_cke", n, 4);
        step();
        chk("ed_dout_p0", int'(dout), 0);
        wait_tick();
        chk("ed_dout_p1", int'(dout), 250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
